// File: rtl/io_sync_pkg.sv
// io_sync_pkg: launch-edge constants and FSM state encodings shared by the output launch path
package io_sync_pkg;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;
endpackage

// File: rtl/output_launch_fifo.sv
// output_launch_fifo: DEPTH x WIDTH circular buffer
// ports: clock/reset, push_i/wdata_i write side, pop_i/rdata_o read side (rdata_o is the head word),
//        count_o occupancy 0..DEPTH, full_o/empty_o flags; a push while full is ignored
module output_launch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/output_launch.sv
// output_launch: buffers core words and launches them on the rising or falling clock edge
// ports: clock, reset (async, active-high), edge_launch (1 rise / 0 fall), in_valid/in_ready/in_data
//        producer handshake, out_stall consumer hold, out_valid/out_data launched word
// OUTPUT_LAUNCH_PARITY_EN adds out_parity = ^out_data, launched through the same registers
module output_launch
  import io_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             edge_launch,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef OUTPUT_LAUNCH_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e           state_q, state_d;
  logic             active_q;
  logic             pos_valid_q, neg_valid_q;
  logic [WIDTH-1:0] pos_data_q, neg_data_q, head;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop, hold, mismatch;
  assign push     = in_valid && in_ready;
  // the word in the launch register is held while the consumer stalls it
  assign hold     = pos_valid_q && out_stall;
  assign pop      = !empty && !hold;
  assign mismatch = edge_launch != active_q;
  output_launch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= EDGE_RISE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SWITCH) active_q <= edge_launch;
    end
  end
  // leaving SEND or DRAIN also waits for a stalled word so nothing launches on a mixed edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = push ? ST_SEND : mismatch ? ST_SWITCH : ST_IDLE;
      ST_SEND:  state_d = mismatch ? ST_DRAIN : (count == '0 && !push && !hold) ? ST_IDLE : ST_SEND;
      ST_DRAIN: state_d = (count == '0 && !hold) ? ST_SWITCH : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    in_ready = !full && state_q != ST_DRAIN && state_q != ST_SWITCH;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_valid_q <= 1'b0;
      pos_data_q  <= '0;
    end else begin
      pos_valid_q <= pop || hold;
      if (pop) pos_data_q <= head;
    end
  end
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      neg_valid_q <= 1'b0;
      neg_data_q  <= '0;
    end else begin
      neg_valid_q <= pos_valid_q;
      neg_data_q  <= pos_data_q;
    end
  end
  assign out_valid = (active_q == EDGE_FALL) ? neg_valid_q : pos_valid_q;
  assign out_data  = (active_q == EDGE_FALL) ? neg_data_q : pos_data_q;
`ifdef OUTPUT_LAUNCH_PARITY_EN
  logic pos_par_q, neg_par_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pos_par_q <= 1'b0;
    else if (pop) pos_par_q <= ^head;
  end
  always_ff @(negedge clock or posedge reset) begin
    if (reset) neg_par_q <= 1'b0;
    else neg_par_q <= pos_par_q;
  end
  assign out_parity = (active_q == EDGE_FALL) ? neg_par_q : pos_par_q;
`endif
endmodule
